stamp_load_scheduler: RTL and testbench

- Sequences all loads of the 64-bit timestamp counter: drives its `restart_time[1:0]` and `ntp_timestamp` inputs from host commands.
- Serialises three operations: immediate load, PPS-aligned load and zero.
- A PPS-aligned load arms the block and is issued on the next PPS edge, with a timeout if GPS is absent.
- Sits between the register/AXI-Lite slave and the stamp counter, in the `axi_aclk` domain.

---
 rtl/stamp_load_scheduler.sv | 159 +++++++++++++++
 tb/tb_stamp_load_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stamp_load_scheduler.sv
// stamp_load_scheduler
//   Sequences every load of the 64-bit timestamp counter from host commands:
//   immediate load (op 01), PPS-aligned load (op 10) and zero (op 11).
//   A PPS-aligned load arms the block and is issued one cycle after the next
//   PPS falling edge, or abandoned with a timeout pulse if no edge arrives.
//
//   Optional build macro: STAMP_SCHED_ABORT_EN adds cmd_abort, which cancels
//   an armed load (abort beats a coincident PPS edge).
//
// Ports (axi_aclk domain, synchronous active-low reset axi_resetn):
//   cmd_valid/cmd_ready   command handshake, ready only in IDLE
//   cmd_op, cmd_time      operation code and load value
//   pps_rx                raw asynchronous PPS pin
//   restart_time[1:0]     bit0 load ntp_timestamp, bit1 zero (one cycle)
//   ntp_timestamp         captured load value, held until next capture
//   busy, done, timeout   status / one-cycle event pulses
//   load_count            saturating count of issued loads and zeros
module stamp_load_scheduler #(
   parameter int          TIMESTAMP_WIDTH = 64,
   parameter logic [31:0] PPS_TIMEOUT     = 32'h1312D000,
   parameter int          CNT_WIDTH       = 16
) (
   input  logic                       axi_aclk,
   input  logic                       axi_resetn,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [1:0]                 cmd_op,
   input  logic [TIMESTAMP_WIDTH-1:0] cmd_time,
   input  logic                       pps_rx,
`ifdef STAMP_SCHED_ABORT_EN
   input  logic                       cmd_abort,
`endif
   output logic [1:0]                 restart_time,
   output logic [TIMESTAMP_WIDTH-1:0] ntp_timestamp,
   output logic                       busy,
   output logic                       done,
   output logic                       timeout,
   output logic [CNT_WIDTH-1:0]       load_count
);

   typedef enum logic [1:0] {IDLE, ARMED, ISSUE} state_t;

   state_t                     state_q;
   logic [31:0]                timer_q;
   logic [2:0]                 pps_sync_q;   // [0]=d1, [1]=d2, [2]=d3
   logic                       cmd_ready_q;
   logic                       busy_q;
   logic                       done_q;
   logic [1:0]                 restart_q;
   logic [TIMESTAMP_WIDTH-1:0] ntp_q;
   logic [CNT_WIDTH-1:0]       load_count_q;
   logic [CNT_WIDTH-1:0]       load_count_d;
   logic                       pps_evt;
   logic                       abort_w;

`ifdef STAMP_SCHED_ABORT_EN
   assign abort_w = cmd_abort;
`else
   assign abort_w = 1'b0;
`endif

   // Falling edge of the synchronised pin: d2 already low, d3 still high.
   assign pps_evt = pps_sync_q[2] & ~pps_sync_q[1];

   assign load_count_d = (&load_count_q) ? load_count_q
                                         : load_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         pps_sync_q   <= '0;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         restart_q    <= 2'b00;
         ntp_q        <= '0;
         load_count_q <= '0;
      end else begin
         pps_sync_q <= {pps_sync_q[1:0], pps_rx};
         restart_q  <= 2'b00;
         done_q     <= 1'b0;
         case (state_q)
            IDLE: begin
               // cmd_ready_q is high throughout IDLE, so valid alone is a transfer.
               if (cmd_valid) begin
                  case (cmd_op)
                     2'b01: begin
                        state_q      <= ISSUE;
                        restart_q    <= 2'b01;
                        ntp_q        <= cmd_time;
                        done_q       <= 1'b1;
                        load_count_q <= load_count_d;
                        cmd_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                     end
                     2'b10: begin
                        state_q     <= ARMED;
                        timer_q     <= PPS_TIMEOUT;
                        ntp_q       <= cmd_time;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                     end
                     2'b11: begin
                        state_q      <= ISSUE;
                        restart_q    <= 2'b10;
                        done_q       <= 1'b1;
                        load_count_q <= load_count_d;
                        cmd_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                     end
                     default: ;
                  endcase
               end
            end
            ARMED: begin
               if (abort_w) begin
                  state_q     <= IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else if (pps_evt) begin
                  state_q      <= ISSUE;
                  restart_q    <= 2'b01;
                  done_q       <= 1'b1;
                  load_count_q <= load_count_d;
               end else if (timer_q == 32'd0) begin
                  state_q     <= IDLE;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  timer_q <= timer_q - 32'd1;
               end
            end
            ISSUE: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   // Decoded so the pulse lands in the ARMED cycle that gives up, and a
   // coincident PPS edge or abort suppresses it.
   assign timeout = (state_q == ARMED) && (timer_q == 32'd0) && !pps_evt && !abort_w;

   assign cmd_ready     = cmd_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign restart_time  = restart_q;
   assign ntp_timestamp = ntp_q;
   assign load_count    = load_count_q;

endmodule

// File: tb/tb_stamp_load_scheduler.sv
// Bench for stamp_load_scheduler: cycle-numbered reference model checked on
// every negedge, plus directed literal expectations.
module tb_stamp_load_scheduler;
   localparam int TW = 64;
   localparam int PT = 100;
   localparam int CW = 4;

   logic          axi_aclk = 1'b0;
   logic          axi_resetn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [TW-1:0] cmd_time;
   logic          pps_rx;
`ifdef STAMP_SCHED_ABORT_EN
   logic          cmd_abort;
`endif
   logic [1:0]    restart_time;
   logic [TW-1:0] ntp_timestamp;
   logic          busy, done, timeout;
   logic [CW-1:0] load_count;

   always #5 axi_aclk = ~axi_aclk;

   stamp_load_scheduler #(
      .TIMESTAMP_WIDTH(TW),
      .PPS_TIMEOUT    (32'd100),
      .CNT_WIDTH      (CW)
   ) dut (
      .axi_aclk     (axi_aclk),
      .axi_resetn   (axi_resetn),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_time     (cmd_time),
      .pps_rx       (pps_rx),
`ifdef STAMP_SCHED_ABORT_EN
      .cmd_abort    (cmd_abort),
`endif
      .restart_time (restart_time),
      .ntp_timestamp(ntp_timestamp),
      .busy         (busy),
      .done         (done),
      .timeout      (timeout),
      .load_count   (load_count)
   );

   int cyc = 0;
   always @(posedge axi_aclk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model (cycle-number arithmetic) -------------
   // Cycle c = interval after the c-th posedge; inputs set in cycle c are
   // sampled at the end of it. A pin low first in cycle m yields the edge
   // event in cycle m+2 and the load in cycle m+3.
   bit          ph [0:8191];
   bit          chk_en     = 1'b0;
   bit          armed      = 1'b0;
   int          free_at    = 0;
   int          issue_at   = -1;
   int          armed_from = 0;
   int          deadline   = 0;
   int          mcnt       = 0;
   logic [1:0]  issue_rt   = 2'b00;
   logic [63:0] issue_val  = '0;
   logic [63:0] cap_val    = '0;
   int          load_cyc   = -1;
   int          to_cyc     = -1;

   always @(negedge axi_aclk) begin
      int  c;
      bit  evt, e_to, ab;
      c    = cyc;
      e_to = 1'b0;
`ifdef STAMP_SCHED_ABORT_EN
      ab = cmd_abort;
`else
      ab = 1'b0;
`endif
      evt = (c >= 3) && ph[c-3] && !ph[c-2];
      if (armed && c >= armed_from) begin
         if (ab) begin
            armed = 1'b0; free_at = c + 1;
         end else if (evt) begin
            armed = 1'b0; issue_at = c + 1; issue_rt = 2'b01;
            issue_val = cap_val; free_at = c + 2;
         end else if (c == deadline) begin
            armed = 1'b0; e_to = 1'b1; free_at = c + 1;
         end
      end
      if (issue_at == c) mcnt = (mcnt == 15) ? 15 : mcnt + 1;
      if (chk_en) begin
         chk("cmd_ready",    64'(cmd_ready),    64'(c >= free_at));
         chk("busy",         64'(busy),         64'(c < free_at));
         chk("restart_time", 64'(restart_time), 64'((issue_at == c) ? issue_rt : 2'b00));
         chk("done",         64'(done),         64'(issue_at == c));
         chk("timeout",      64'(timeout),      64'(e_to));
         chk("load_count",   64'(load_count),   64'(mcnt));
         if (issue_at == c && issue_rt == 2'b01)
            chk("ntp_timestamp", ntp_timestamp, issue_val);
      end
      if (restart_time == 2'b01) load_cyc = c;
      if (timeout) to_cyc = c;
      ph[c] = pps_rx;
      if (!axi_resetn) begin
         armed = 1'b0; issue_at = -1; free_at = c + 1; mcnt = 0; chk_en = 1'b1;
         ph[c] = 1'b0;
         if (c >= 1) ph[c-1] = 1'b0;
         if (c >= 2) ph[c-2] = 1'b0;
      end else if (c >= free_at && cmd_valid) begin
         case (cmd_op)
            2'b01: begin
               issue_at = c + 1; issue_rt = 2'b01; issue_val = cmd_time;
               cap_val = cmd_time; free_at = c + 2;
            end
            2'b10: begin
               armed = 1'b1; armed_from = c + 1; deadline = c + 1 + PT;
               cap_val = cmd_time; free_at = 1 << 30;
            end
            2'b11: begin
               issue_at = c + 1; issue_rt = 2'b10; free_at = c + 2;
            end
            default: ;
         endcase
      end
   end

   // ---------------- stimulus ----------------------------------------------
   task automatic tick();
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [63:0] t, output int acc);
      for (int k = 0; k < 300 && !cmd_ready; k++) tick();
      chk("send_ready", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_op = op; cmd_time = t;
      acc = cyc;
      tick();
      cmd_valid = 1'b0; cmd_op = 2'b00;
   endtask

   initial begin
      int n, a, m, t, prev_load, prev_to;
      axi_resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_time = '0; pps_rx = 1'b0;
`ifdef STAMP_SCHED_ABORT_EN
      cmd_abort = 1'b0;
`endif
      repeat (3) tick();
      axi_resetn = 1'b1;
      repeat (10) tick();
      @(negedge axi_aclk);
      chk("rst_ready", 64'(cmd_ready), 64'd1);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_rt",    64'(restart_time), 64'd0);
      chk("rst_cnt",   64'(load_count), 64'd0);

      // immediate load
      send(2'b01, 64'h0000_0001_2345_6780, n);
      @(negedge axi_aclk);
      chk("now_rt",   64'(restart_time), 64'd1);
      chk("now_done", 64'(done), 64'd1);
      chk("now_ntp",  ntp_timestamp, 64'h0000_0001_2345_6780);
      tick();
      @(negedge axi_aclk);
      chk("now_ready", 64'(cmd_ready), 64'd1);
      chk("now_cnt",   64'(load_count), 64'd1);

      // PPS-aligned load; a command offered while armed is dropped
      send(2'b10, 64'hAAAA_BBBB_CCCC_DDDD, a);
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_time = 64'h1;
      repeat (3) tick();
      cmd_valid = 1'b0;
      chk("armed_ready", 64'(cmd_ready), 64'd0);
      pps_rx = 1'b1;
      repeat (20) tick();
      pps_rx = 1'b0; m = cyc;
      repeat (8) tick();
      chk("pps_load_cycle", 64'(load_cyc), 64'(m + 3));
      chk("pps_cnt", 64'(load_count), 64'd2);
      chk("pps_ntp", ntp_timestamp, 64'hAAAA_BBBB_CCCC_DDDD);

      // PPS edge before accept is stale -> timeout
      prev_load = load_cyc;
      pps_rx = 1'b1;
      repeat (5) tick();
      pps_rx = 1'b0; m = cyc;
      repeat (2) tick();
      send(2'b10, 64'h5, t);
      repeat (108) tick();
      chk("to_cycle", 64'(to_cyc), 64'(t + 101));
      chk("to_noload", 64'(load_cyc), 64'(prev_load));
      chk("to_cnt", 64'(load_count), 64'd2);

      // zero
      send(2'b11, 64'h0, n);
      @(negedge axi_aclk);
      chk("zero_rt", 64'(restart_time), 64'd2);
      tick();
      @(negedge axi_aclk);
      chk("zero_rt_clr", 64'(restart_time), 64'd0);
      chk("zero_cnt", 64'(load_count), 64'd3);

      // PPS edge in the same cycle the timer reaches zero: load, no timeout
      prev_to = to_cyc;
      pps_rx = 1'b1;
      send(2'b10, 64'h1234, t);
      for (int k = 0; k < 200 && cyc < t + 99; k++) tick();
      pps_rx = 1'b0;
      repeat (8) tick();
      chk("tie_load_cycle", 64'(load_cyc), 64'(t + 102));
      chk("tie_no_timeout", 64'(to_cyc), 64'(prev_to));
      chk("tie_cnt", 64'(load_count), 64'd4);

      // nop
      send(2'b00, 64'hFF, n);
      repeat (3) tick();
      chk("nop_cnt", 64'(load_count), 64'd4);

      // reset while armed
      send(2'b10, 64'h77, t);
      repeat (5) tick();
      axi_resetn = 1'b0;
      tick();
      axi_resetn = 1'b1;
      @(negedge axi_aclk);
      chk("rst_armed_ready", 64'(cmd_ready), 64'd1);
      chk("rst_armed_cnt",   64'(load_count), 64'd0);
      repeat (3) tick();

      // counter saturation
      for (int i = 0; i < 18; i++) begin
         send(2'b01, 64'(i), n);
         tick();
      end
      chk("sat_cnt", 64'(load_count), 64'd15);

`ifdef STAMP_SCHED_ABORT_EN
      // abort coinciding with the PPS event: nothing issued
      prev_load = load_cyc;
      pps_rx = 1'b1;
      send(2'b10, 64'h99, t);
      repeat (4) tick();
      pps_rx = 1'b0; m = cyc;
      repeat (2) tick();
      cmd_abort = 1'b1;
      tick();
      cmd_abort = 1'b0;
      repeat (5) tick();
      chk("abort_noload", 64'(load_cyc), 64'(prev_load));
      chk("abort_ready", 64'(cmd_ready), 64'd1);
      // abort outside ARMED has no effect
      cmd_abort = 1'b1;
      send(2'b01, 64'h42, n);
      cmd_abort = 1'b0;
      @(negedge axi_aclk);
      chk("abort_idle_load", 64'(restart_time), 64'd1);
      tick();
`endif

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
